alu_arbiter: RTL and testbench

Two-port arbiter that shares one accumulator ALU (12-bit instruction: opcode [11:8], immediate [7:0]; opcodes 0x0–0x9 legal) between two requesters. It does three things:
- Forwards one instruction per cycle to the ALU.
- Captures the ALU's same-cycle result and returns it to the issuing port.
- Supports an optional lock, so a requester can run a multi-instruction sequence on the shared accumulator without interleaving.

It sits directly in front of the ALU and drives its `inst` and `inst_wen` inputs.

---
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared accumulator ALU; the ALU's same-cycle result is captured back to the issuing port.
// Optional `ALU_ARBITER_LOCK_EN` lets a port hold exclusive ownership across a multi-instruction sequence.

module alu_arbiter_port (
  input  logic       clock,
  input  logic       reset,
  input  logic       accept,
  input  logic       legal,
  input  logic [7:0] alu_result,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       err
);
  always_ff @(posedge clock) begin
    if (reset) begin
      result       <= 8'h00;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      result_valid <= accept && legal;
      err          <= accept && !legal;
      if (accept && legal) result <= alu_result;
    end
  end
endmodule

module alu_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [11:0] req0_inst,
  input  logic        req0_lock,
  output logic        req0_ready,
  output logic [7:0]  req0_result,
  output logic        req0_result_valid,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic [11:0] req1_inst,
  input  logic        req1_lock,
  output logic        req1_ready,
  output logic [7:0]  req1_result,
  output logic        req1_result_valid,
  output logic        req1_err,
  output logic [11:0] alu_inst,
  output logic        alu_inst_wen,
  input  logic [7:0]  alu_result
);
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {RESET, IDLE, OWN0, OWN1} state_t;
  typedef struct packed {
    logic        valid;
    logic        lock;
    logic [11:0] inst;
  } req_t;

  state_t                          state;
  logic                            last;
  req_t [NUM_PORTS-1:0]            req;
  logic [NUM_PORTS-1:0]            grant, accept;
  logic [11:0]                     sel_inst;
  logic                            legal;
  logic [NUM_PORTS-1:0][7:0]       result;
  logic [NUM_PORTS-1:0]            result_valid, err;

  assign req[0] = {req0_valid, req0_lock, req0_inst};
  assign req[1] = {req1_valid, req1_lock, req1_inst};

  always_comb begin
    grant = '0;
    case (state)
      IDLE:
        if (req[0].valid && req[1].valid) grant = last ? 2'b01 : 2'b10;
        else                              grant = {req[1].valid, req[0].valid};
      OWN0:    grant[0] = req[0].valid;
      OWN1:    grant[1] = req[1].valid;
      default: grant = '0;
    endcase
  end

  assign accept   = grant & {req[1].valid, req[0].valid};
  assign sel_inst = accept[1] ? req[1].inst : req[0].inst;
  // Illegal opcodes are swallowed here so the ALU never sees them and never enters its sticky error state.
  assign legal        = sel_inst[11:8] <= 4'h9;
  assign alu_inst_wen = (|accept) && legal;
  assign alu_inst     = alu_inst_wen ? sel_inst : 12'h000;

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RESET;
      last  <= 1'b1;
    end else begin
      if (|accept) last <= accept[1];
      case (state)
        RESET: state <= IDLE;
`ifdef ALU_ARBITER_LOCK_EN
        IDLE:
          if (accept[0] && req[0].lock)      state <= OWN0;
          else if (accept[1] && req[1].lock) state <= OWN1;
        OWN0: if (!req[0].lock) state <= IDLE;
        OWN1: if (!req[1].lock) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifndef ALU_ARBITER_LOCK_EN
  logic unused_lock;
  assign unused_lock = req[0].lock | req[1].lock;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    alu_arbiter_port u_port (
      .clock        (clock),
      .reset        (reset),
      .accept       (accept[p]),
      .legal        (legal),
      .alu_result   (alu_result),
      .result       (result[p]),
      .result_valid (result_valid[p]),
      .err          (err[p])
    );
  end

  assign req0_result       = result[0];
  assign req0_result_valid = result_valid[0];
  assign req0_err          = err[0];
  assign req1_result       = result[1];
  assign req1_result_valid = result_valid[1];
  assign req1_err          = err[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed vector bench for alu_arbiter with a small accumulator ALU model driving alu_result.
module tb_alu_arbiter;
  logic        clock, reset;
  logic        req0_valid, req0_lock, req1_valid, req1_lock;
  logic [11:0] req0_inst, req1_inst;
  logic        req0_ready, req1_ready, req0_result_valid, req1_result_valid, req0_err, req1_err;
  logic [7:0]  req0_result, req1_result, alu_result;
  logic [11:0] alu_inst;
  logic        alu_inst_wen;
  logic [7:0]  acc;

  int checks = 0;
  int errors = 0;

  alu_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_inst(req0_inst), .req0_lock(req0_lock), .req0_ready(req0_ready),
    .req0_result(req0_result), .req0_result_valid(req0_result_valid), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_inst(req1_inst), .req1_lock(req1_lock), .req1_ready(req1_ready),
    .req1_result(req1_result), .req1_result_valid(req1_result_valid), .req1_err(req1_err),
    .alu_inst(alu_inst), .alu_inst_wen(alu_inst_wen), .alu_result(alu_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ALU model: 1 load, 2 add, 3 sub, 4 and, 6 or, 9 xor, others keep the accumulator.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [11:0] i);
    case (i[11:8])
      4'h1:    return i[7:0];
      4'h2:    return a + i[7:0];
      4'h3:    return a - i[7:0];
      4'h4:    return a & i[7:0];
      4'h6:    return a | i[7:0];
      4'h9:    return a ^ i[7:0];
      default: return a;
    endcase
  endfunction

  assign alu_result = alu_inst_wen ? alu_f(acc, alu_inst) : acc;
  always_ff @(posedge clock)
    if (reset) acc <= 8'h00;
    else if (alu_inst_wen) acc <= alu_f(acc, alu_inst);

  typedef struct {
    logic        rst;
    logic        v0;
    logic [11:0] i0;
    logic        l0;
    logic        v1;
    logic [11:0] i1;
    logic        l1;
    logic [1:0]  rdy;   // {req1_ready, req0_ready}
    logic        wen;
    logic [11:0] ai;
    logic [7:0]  r0;
    logic [7:0]  r1;
    logic [3:0]  p;     // {rv0, err0, rv1, err1} after the edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic v0, input logic [11:0] i0, input logic l0,
                              input logic v1, input logic [11:0] i1, input logic l1,
                              input logic [1:0] rdy, input logic wen, input logic [11:0] ai,
                              input logic [7:0] r0, input logic [7:0] r1, input logic [3:0] p);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.i0 = i0; v.l0 = l0; v.v1 = v1; v.i1 = i1; v.l1 = l1;
    v.rdy = rdy; v.wen = wen; v.ai = ai; v.r0 = r0; v.r1 = r1; v.p = p;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL vec%0d %s got %h expected %h", idx, name, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_inst = '0; req0_lock = 0;
    req1_valid = 0; req1_inst = '0; req1_lock = 0;

    // Reset wait: first cycle after release must not accept.
    vecs.push_back(mk(1, 0,12'h000,0, 0,12'h000,0, 2'b00,0,12'h000, 8'h00,8'h00,4'b0000));
    vecs.push_back(mk(1, 0,12'h000,0, 0,12'h000,0, 2'b00,0,12'h000, 8'h00,8'h00,4'b0000));
    vecs.push_back(mk(0, 1,12'h105,0, 0,12'h000,0, 2'b00,0,12'h000, 8'h00,8'h00,4'b0000));
    vecs.push_back(mk(0, 1,12'h105,0, 0,12'h000,0, 2'b01,1,12'h105, 8'h05,8'h00,4'b1000));
    // Round-robin tie from a fresh reset: port 0 wins first.
    vecs.push_back(mk(1, 0,12'h000,0, 0,12'h000,0, 2'b00,0,12'h000, 8'h00,8'h00,4'b0000));
    vecs.push_back(mk(0, 1,12'h201,0, 1,12'h202,0, 2'b00,0,12'h000, 8'h00,8'h00,4'b0000));
    vecs.push_back(mk(0, 1,12'h201,0, 1,12'h202,0, 2'b01,1,12'h201, 8'h01,8'h00,4'b1000));
    vecs.push_back(mk(0, 1,12'h201,0, 1,12'h202,0, 2'b10,1,12'h202, 8'h01,8'h03,4'b0010));
    vecs.push_back(mk(0, 1,12'h201,0, 1,12'h202,0, 2'b01,1,12'h201, 8'h04,8'h03,4'b1000));
    vecs.push_back(mk(0, 1,12'h201,0, 1,12'h202,0, 2'b10,1,12'h202, 8'h04,8'h06,4'b0010));
    // Illegal opcodes are rejected without reaching the ALU; the next legal one works.
    vecs.push_back(mk(0, 0,12'h000,0, 1,12'hA00,0, 2'b10,0,12'h000, 8'h04,8'h06,4'b0001));
    vecs.push_back(mk(0, 0,12'h000,0, 1,12'h201,0, 2'b10,1,12'h201, 8'h04,8'h07,4'b0010));
    vecs.push_back(mk(0, 1,12'hF12,0, 0,12'h000,0, 2'b01,0,12'h000, 8'h04,8'h07,4'b0100));
    vecs.push_back(mk(0, 0,12'h000,0, 0,12'h000,0, 2'b00,0,12'h000, 8'h04,8'h07,4'b0000));
    vecs.push_back(mk(0, 1,12'h203,0, 1,12'h201,0, 2'b10,1,12'h201, 8'h04,8'h08,4'b0010));
    // Locked sequence on port 0 with port 1 waiting.
    vecs.push_back(mk(1, 0,12'h000,0, 0,12'h000,0, 2'b00,0,12'h000, 8'h00,8'h00,4'b0000));
    vecs.push_back(mk(0, 1,12'h1F0,1, 1,12'h205,0, 2'b00,0,12'h000, 8'h00,8'h00,4'b0000));
    vecs.push_back(mk(0, 1,12'h1F0,1, 1,12'h205,0, 2'b01,1,12'h1F0, 8'hF0,8'h00,4'b1000));
`ifdef ALU_ARBITER_LOCK_EN
    vecs.push_back(mk(0, 1,12'h60F,1, 1,12'h205,0, 2'b01,1,12'h60F, 8'hFF,8'h00,4'b1000));
    vecs.push_back(mk(0, 0,12'h000,1, 1,12'h205,0, 2'b00,0,12'h000, 8'hFF,8'h00,4'b0000));
    vecs.push_back(mk(0, 1,12'h901,0, 1,12'h205,0, 2'b01,1,12'h901, 8'hFE,8'h00,4'b1000));
    vecs.push_back(mk(0, 0,12'h000,0, 1,12'h205,0, 2'b10,1,12'h205, 8'hFE,8'h03,4'b0010));
`else
    vecs.push_back(mk(0, 1,12'h60F,1, 1,12'h205,0, 2'b10,1,12'h205, 8'hF0,8'hF5,4'b0010));
    vecs.push_back(mk(0, 0,12'h000,1, 1,12'h205,0, 2'b10,1,12'h205, 8'hF0,8'hFA,4'b0010));
    vecs.push_back(mk(0, 1,12'h901,0, 1,12'h205,0, 2'b01,1,12'h901, 8'hFB,8'hFA,4'b1000));
    vecs.push_back(mk(0, 0,12'h000,0, 1,12'h205,0, 2'b10,1,12'h205, 8'hFB,8'h00,4'b0010));
`endif
    // Reset while port 1 owns the ALU with a result pending; pointer returns to 1.
    vecs.push_back(mk(1, 0,12'h000,0, 0,12'h000,0, 2'b00,0,12'h000, 8'h00,8'h00,4'b0000));
    vecs.push_back(mk(0, 0,12'h000,0, 1,12'h102,1, 2'b00,0,12'h000, 8'h00,8'h00,4'b0000));
    vecs.push_back(mk(0, 0,12'h000,0, 1,12'h102,1, 2'b10,1,12'h102, 8'h00,8'h02,4'b0010));
    vecs.push_back(mk(1, 0,12'h000,0, 1,12'h103,1, 2'b00,0,12'h000, 8'h00,8'h00,4'b0000));
    vecs.push_back(mk(0, 1,12'h201,0, 1,12'h202,0, 2'b00,0,12'h000, 8'h00,8'h00,4'b0000));
    vecs.push_back(mk(0, 1,12'h201,0, 1,12'h202,0, 2'b01,1,12'h201, 8'h01,8'h00,4'b1000));

    @(posedge clock); #1;
    for (int k = 0; k < vecs.size(); k++) begin
      reset      = vecs[k].rst;
      req0_valid = vecs[k].v0; req0_inst = vecs[k].i0; req0_lock = vecs[k].l0;
      req1_valid = vecs[k].v1; req1_inst = vecs[k].i1; req1_lock = vecs[k].l1;
      @(negedge clock);
      if (!vecs[k].rst) begin
        chk("ready", k, {10'd0, req1_ready, req0_ready}, {10'd0, vecs[k].rdy});
        chk("alu_inst_wen", k, {11'd0, alu_inst_wen}, {11'd0, vecs[k].wen});
        chk("alu_inst", k, alu_inst, vecs[k].ai);
      end
      @(posedge clock); #1;
      chk("req0_result", k, {4'd0, req0_result}, {4'd0, vecs[k].r0});
      chk("req1_result", k, {4'd0, req1_result}, {4'd0, vecs[k].r1});
      chk("pulses", k, {8'd0, req0_result_valid, req0_err, req1_result_valid, req1_err},
          {8'd0, vecs[k].p});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
